// File: rtl/uart_rx_ram_writer_if.sv
// Bus between the UART receive-side RAM writer and its environment:
// serial input, oversample tick and enable toward the writer, and the
// RAM port-A write signals plus status pulses back out.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_rx_ram_writer_if #(
    parameter int WIDTH_DATA  = 16,
    parameter int LENGTH_ADDR = 10
);
    logic                   en;
    logic                   rx_en;
    logic                   RxD;
    logic                   wen;
    logic [LENGTH_ADDR-1:0] addr;
    logic [WIDTH_DATA-1:0]  din;
    logic                   frame_err;
    logic                   wrap;
    logic                   busy;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err;

    modport master (
        input  en, rx_en, RxD,
        output wen, addr, din, frame_err, wrap, busy, parity_err
    );
    modport slave (
        output en, rx_en, RxD,
        input  wen, addr, din, frame_err, wrap, busy, parity_err
    );
`else
    modport master (
        input  en, rx_en, RxD,
        output wen, addr, din, frame_err, wrap, busy
    );
    modport slave (
        output en, rx_en, RxD,
        input  wen, addr, din, frame_err, wrap, busy
    );
`endif
endinterface

// File: rtl/uart_rx_ram_writer.sv
// UART receiver (8N1) that packs bytes LSB-first into WIDTH_DATA-bit words
// and writes each completed word to RAM port A at an auto-incrementing,
// wrapping address. Bit timing comes from an external oversample tick.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after the
// data bits and a parity_err pulse output.
`timescale 1ns/1ps
module uart_rx_ram_writer #(
    parameter int WIDTH_DATA  = 16,
    parameter int LENGTH_ADDR = 10,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_ram_writer_if.master  bus
);
    localparam int BYTES  = WIDTH_DATA / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W  = $clog2(OVERSAMPLE);

    localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]       HALF_M1   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]       FULL_M1   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [LANE_W-1:0]      LANE_ZERO = {LANE_W{1'b0}};
    localparam logic [LANE_W-1:0]      LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(BYTES - 1);
    localparam logic [LENGTH_ADDR-1:0] ADDR_ZERO = {LENGTH_ADDR{1'b0}};
    localparam logic [LENGTH_ADDR-1:0] ADDR_ONE  = LENGTH_ADDR'(1);
    localparam logic [LENGTH_ADDR-1:0] LAST_ADDR = {LENGTH_ADDR{1'b1}};
    localparam logic [WIDTH_DATA-1:0]  DATA_ZERO = {WIDTH_DATA{1'b0}};

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even-parity bit for a byte: the value that makes the total count of ones even.
    function automatic logic calc_even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    // Synchroniser and FSM state
    logic                   sync1_r;
    logic                   rxs_r;
    state_t                 state_r,     state_s;
    logic [CNT_W-1:0]       cnt_r,       cnt_s;
    logic [2:0]             bit_r,       bit_s;
    logic [7:0]             shift_r,     shift_s;
    logic [LANE_W-1:0]      lane_r,      lane_s;
    logic [WIDTH_DATA-1:0]  word_r,      word_s;
    logic                   need_high_r, need_high_s;
    logic [LENGTH_ADDR-1:0] ptr_r;
    logic [WIDTH_DATA-1:0]  packed_s;
    logic                   commit_s;
    logic                   ferr_s;

    // Registered outputs
    logic                   wen_r;
    logic [LENGTH_ADDR-1:0] addr_r;
    logic [WIDTH_DATA-1:0]  din_r;
    logic                   frame_err_r;
    logic                   wrap_r;
    logic                   busy_r;

`ifdef UART_RX_PARITY_EN
    logic                   par_bad_r, par_bad_s;
    logic                   perr_s;
    logic                   parity_err_r;
`endif

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= bus.RxD;
            rxs_r   <= sync1_r;
        end
    end

    // Next-state, datapath and pulse decode for the receive FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_s       = bit_r;
        shift_s     = shift_r;
        lane_s      = lane_r;
        word_s      = word_r;
        need_high_s = need_high_r;
        commit_s    = 1'b0;
        ferr_s      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_s   = par_bad_r;
        perr_s      = 1'b0;
`endif

        // Current partial word with the just-received byte in its lane.
        packed_s = word_r;
        for (int i = 0; i < BYTES; i++) begin
            if (lane_r == LANE_W'(i)) begin
                packed_s[8*i +: 8] = shift_r;
            end else begin
                packed_s[8*i +: 8] = word_r[8*i +: 8];
            end
        end

        case (state_r)
            IDLE: begin
                // After a bad stop bit the line must return high before a
                // new falling level counts as a start.
                if (rxs_r) begin
                    need_high_s = 1'b0;
                end else begin
                    need_high_s = need_high_r;
                end
                if (bus.en && !rxs_r && !need_high_r) begin
                    state_s = START;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                if (bus.rx_en) begin
                    if (cnt_r == HALF_M1) begin
                        cnt_s = CNT_ZERO;
                        if (rxs_r) begin
                            state_s = IDLE;          // false start, no error
                        end else begin
                            state_s = DATA;
                            bit_s   = 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_bad_s = 1'b0;
`endif
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end

            DATA: begin
                if (bus.rx_en) begin
                    if (cnt_r == FULL_M1) begin
                        cnt_s   = CNT_ZERO;
                        shift_s = {rxs_r, shift_r[7:1]};
                        if (bit_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_s = PARITY;
`else
                            state_s = STOP;
`endif
                        end else begin
                            bit_s = bit_r + 3'd1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.rx_en) begin
                    if (cnt_r == FULL_M1) begin
                        cnt_s     = CNT_ZERO;
                        state_s   = STOP;
                        par_bad_s = (rxs_r != calc_even_parity(shift_r));
                        perr_s    = par_bad_s;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
`endif

            STOP: begin
                if (bus.rx_en) begin
                    if (cnt_r == FULL_M1) begin
                        cnt_s   = CNT_ZERO;
                        state_s = IDLE;
                        if (!rxs_r) begin
                            // Bad stop bit: drop byte and any partial word.
                            ferr_s      = 1'b1;
                            lane_s      = LANE_ZERO;
                            need_high_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_r) begin
                            lane_s = LANE_ZERO;
`endif
                        end else if (lane_r == LAST_LANE) begin
                            lane_s   = LANE_ZERO;
                            commit_s = 1'b1;
                        end else begin
                            word_s = packed_s;
                            lane_s = lane_r + LANE_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            bit_r        <= 3'd0;
            shift_r      <= 8'h00;
            lane_r       <= LANE_ZERO;
            word_r       <= DATA_ZERO;
            need_high_r  <= 1'b0;
            ptr_r        <= ADDR_ZERO;
            wen_r        <= 1'b0;
            addr_r       <= ADDR_ZERO;
            din_r        <= DATA_ZERO;
            frame_err_r  <= 1'b0;
            wrap_r       <= 1'b0;
            busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_r       <= bit_s;
            shift_r     <= shift_s;
            lane_r      <= lane_s;
            word_r      <= word_s;
            need_high_r <= need_high_s;
            // Pointer advances the clock after the write so addr shows
            // the written location during wen.
            if (wen_r) begin
                ptr_r <= ptr_r + ADDR_ONE;
            end
            wen_r       <= commit_s;
            wrap_r      <= commit_s && (ptr_r == LAST_ADDR);
            if (commit_s) begin
                addr_r <= ptr_r;
                din_r  <= packed_s;
            end
            frame_err_r <= ferr_s;
            busy_r      <= (state_s != IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= par_bad_s;
            parity_err_r <= perr_s;
`endif
        end
    end

    assign bus.wen       = wen_r;
    assign bus.addr      = addr_r;
    assign bus.din       = din_r;
    assign bus.frame_err = frame_err_r;
    assign bus.wrap      = wrap_r;
    assign bus.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_ram_writer.sv
// Directed self-checking bench for uart_rx_ram_writer.
// A small address width keeps the wrap-around stream short; rx_en ticks
// every other clock, so one bit lasts 2*OVERSAMPLE clocks.
`timescale 1ns/1ps
module tb_uart_rx_ram_writer;
    localparam int WD       = 16;
    localparam int LA       = 5;
    localparam int OS       = 16;
    localparam int DEPTH    = 1 << LA;
    localparam int BIT_CLKS = 2 * OS;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    uart_rx_ram_writer_if #(.WIDTH_DATA(WD), .LENGTH_ADDR(LA)) bus ();

    uart_rx_ram_writer #(
        .WIDTH_DATA (WD),
        .LENGTH_ADDR(LA),
        .OVERSAMPLE (OS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Oversample tick: high for one clock out of every two.
    initial begin
        bus.rx_en = 1'b0;
        forever begin
            @(negedge clk);
            bus.rx_en = ~bus.rx_en;
        end
    end

    // Monitor: log writes and count pulses, sampled on the falling edge.
    logic [LA-1:0] log_addr[$];
    logic [WD-1:0] log_din[$];
    logic          log_wrap[$];
    int frame_cnt = 0, parity_cnt = 0, busy_cnt = 0, stray_wrap = 0;
    int wen_run = 0, wen_max = 0, ferr_run = 0, ferr_max = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wen === 1'b1) begin
                log_addr.push_back(bus.addr);
                log_din.push_back(bus.din);
                log_wrap.push_back(bus.wrap);
                wen_run++;
            end else begin
                wen_run = 0;
                if (bus.wrap === 1'b1) stray_wrap++;
            end
            if (wen_run > wen_max) wen_max = wen_run;
            if (bus.frame_err === 1'b1) begin
                frame_cnt++;
                ferr_run++;
            end else begin
                ferr_run = 0;
            end
            if (ferr_run > ferr_max) ferr_max = ferr_run;
            if (bus.busy === 1'b1) busy_cnt++;
`ifdef UART_RX_PARITY_EN
            if (bus.parity_err === 1'b1) parity_cnt++;
`endif
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.RxD = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`endif
        send_bit(stop_bit);
        bus.RxD = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1, ^b);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_good(w[7:0]);
        send_good(w[15:8]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wen"},       64'(bus.wen),       64'h0);
        check({tag, "_addr"},      64'(bus.addr),      64'h0);
        check({tag, "_din"},       64'(bus.din),       64'h0);
        check({tag, "_frame_err"}, 64'(bus.frame_err), 64'h0);
        check({tag, "_wrap"},      64'(bus.wrap),      64'h0);
        check({tag, "_busy"},      64'(bus.busy),      64'h0);
    endtask

    int base, fbase, bbase, pbase;

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.RxD = 1'b1;
        repeat (4) @(negedge clk);
        check_zero_outputs("reset");
        rst    = 1'b0;
        bus.en = 1'b1;
        repeat (4) @(negedge clk);

        // 1: two words, LSB byte first
        base  = log_addr.size();
        bbase = busy_cnt;
        send_good(8'h34);
        check("t1_no_write_half_word", 64'(log_addr.size() - base), 64'd0);
        check("t1_busy_during_frame", 64'(busy_cnt > bbase), 64'd1);
        send_good(8'h12);
        check("t1_writes", 64'(log_addr.size() - base), 64'd1);
        if (log_addr.size() - base >= 1) begin
            check("t1_addr0", 64'(log_addr[base]), 64'h0);
            check("t1_din0",  64'(log_din[base]),  64'h1234);
            check("t1_wrap0", 64'(log_wrap[base]), 64'h0);
        end
        send_word(16'hABCD);
        check("t1_writes2", 64'(log_addr.size() - base), 64'd2);
        if (log_addr.size() - base >= 2) begin
            check("t1_addr1", 64'(log_addr[base+1]), 64'h1);
            check("t1_din1",  64'(log_din[base+1]),  64'hABCD);
        end
        check("t1_busy_idle", 64'(bus.busy), 64'h0);

        // 2: short low glitch is a false start
        base  = log_addr.size();
        fbase = frame_cnt;
        bbase = busy_cnt;
        bus.RxD = 1'b0;
        repeat (6) @(negedge clk);
        bus.RxD = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("t2_entered_start", 64'(busy_cnt > bbase), 64'd1);
        check("t2_busy_back", 64'(bus.busy), 64'h0);
        check("t2_no_write", 64'(log_addr.size() - base), 64'd0);
        check("t2_no_ferr", 64'(frame_cnt - fbase), 64'd0);

        // 3: bad stop bits drop the byte and the partial word
        do_reset();
        base  = log_addr.size();
        fbase = frame_cnt;
        send_byte(8'h34, 1'b0, ^8'h34);
        send_bit(1'b1);
        check("t3_ferr_first", 64'(frame_cnt - fbase), 64'd1);
        send_good(8'h11);
        send_byte(8'h22, 1'b0, ^8'h22);
        send_bit(1'b1);
        send_word(16'h5678);
        check("t3_ferr_total", 64'(frame_cnt - fbase), 64'd2);
        check("t3_writes", 64'(log_addr.size() - base), 64'd1);
        if (log_addr.size() - base >= 1) begin
            check("t3_addr", 64'(log_addr[base]), 64'h0);
            check("t3_din",  64'(log_din[base]),  64'h5678);
        end

        // 4: stream DEPTH+1 words of value i, check wrap and overwrite of 0
        do_reset();
        base = log_addr.size();
        for (int i = 0; i <= DEPTH; i++) send_word(16'(i));
        check("t4_writes", 64'(log_addr.size() - base), 64'(DEPTH + 1));
        if (log_addr.size() - base == DEPTH + 1) begin
            for (int j = 0; j <= DEPTH; j++) begin
                check($sformatf("t4_addr%0d", j), 64'(log_addr[base+j]), 64'(j % DEPTH));
                check($sformatf("t4_din%0d", j),  64'(log_din[base+j]),  64'(j));
                check($sformatf("t4_wrap%0d", j), 64'(log_wrap[base+j]), 64'(j == DEPTH - 1));
            end
        end

        // 5: reset in the middle of the second byte of a word
        send_word(16'h1111);
        base = log_addr.size();
        send_good(8'h22);
        bus.RxD = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(i == 2);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_zero_outputs("t5_rst");
        bus.RxD = 1'b1;
        rst = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_word(16'hBEEF);
        check("t5_writes", 64'(log_addr.size() - base), 64'd1);
        if (log_addr.size() - base >= 1) begin
            check("t5_addr", 64'(log_addr[base]), 64'h0);
            check("t5_din",  64'(log_din[base]),  64'hBEEF);
        end

`ifdef UART_RX_PARITY_EN
        // 6: wrong parity drops the byte, correct parity writes
        do_reset();
        base  = log_addr.size();
        pbase = parity_cnt;
        fbase = frame_cnt;
        send_byte(8'h03, 1'b1, 1'b1);
        check("t6_perr", 64'(parity_cnt - pbase), 64'd1);
        check("t6_no_write", 64'(log_addr.size() - base), 64'd0);
        check("t6_no_ferr", 64'(frame_cnt - fbase), 64'd0);
        send_byte(8'h03, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        check("t6_perr_total", 64'(parity_cnt - pbase), 64'd1);
        check("t6_writes", 64'(log_addr.size() - base), 64'd1);
        if (log_addr.size() - base >= 1) begin
            check("t6_addr", 64'(log_addr[base]), 64'h0);
            check("t6_din",  64'(log_din[base]),  64'h0003);
        end
`endif

        check("wen_one_clk", 64'(wen_max), 64'd1);
        check("ferr_one_clk", 64'(ferr_max), 64'd1);
        check("wrap_only_with_wen", 64'(stray_wrap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
